// File: rtl/multicycle_ctrl_gen2_if.sv
// Control bundle between the multicycle controller and its datapath.
// master: controller side (takes IR fields and mem_ready, drives enables/selects,
//         state_o and the retired-instruction count).
// slave:  datapath side, the mirror image.
interface multicycle_ctrl_gen2_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       OpCode;
    logic [5:0]       Funct;
    logic             mem_ready;

    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemWrite;
    logic             MemRead;
    logic             IRWrite;
    logic             RegWrite;
    logic             ExtOp;
    logic             LuiOp;
    logic [1:0]       MemtoReg;
    logic [1:0]       RegDst;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       PCSource;
    logic [3:0]       ALUOp;
    logic             BranchNe;
    logic             Exception;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] retired;

    modport master (
        input  OpCode, Funct, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, RegWrite,
               ExtOp, LuiOp, MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource,
               ALUOp, BranchNe, Exception, state_o, retired
    );

    modport slave (
        output OpCode, Funct, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, RegWrite,
               ExtOp, LuiOp, MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource,
               ALUOp, BranchNe, Exception, state_o, retired
    );
endinterface

// File: rtl/multicycle_ctrl_gen2.sv
// Multicycle MIPS-style main controller: IF/ID/EX/MEM/WB/TRAP sequencer whose
// datapath controls are combinational decodes of the state register and the
// IR fields, plus a retired-instruction counter.
// Ports: clk       - rising-edge clock
//        reset     - asynchronous active-low reset
//        bus       - master modport: OpCode/Funct/mem_ready in; enables,
//                    selects, ALUOp, BranchNe, Exception, state_o, retired out
module multicycle_ctrl_gen2 #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter bit          EXT_BRANCH    = 1'b1,
    parameter bit          ILLEGAL_TRAP  = 1'b1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_ctrl_gen2_if.master      bus
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_write;
        logic       mem_read;
        logic       ir_write;
        logic       reg_write;
        logic       ext_op;
        logic       lui_op;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic       branch_ne;
        logic       exception;
    } ctl_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    ctl_t             ctl_c, ctl_out_c;

    logic [5:0] op, fn;
    logic       r_type, funct_ok, shift_fn, jr_fn, jalr_fn;
    logic       is_r_alu, is_jr, is_jalr, is_j, is_jal, is_br;
    logic       is_lw, is_sw, is_lui, is_imm_alu, is_itype, legal;
    logic       mem_go;
    logic [2:0] alu_lo;
    logic       retire_c;

    assign op     = bus.OpCode;
    assign fn     = bus.Funct;
    assign mem_go = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    // Funct classification for R-type instructions
    always_comb begin
        funct_ok = 1'b0;
        shift_fn = 1'b0;
        jr_fn    = 1'b0;
        jalr_fn  = 1'b0;
        case (fn)
            6'h00, 6'h02, 6'h03: begin funct_ok = 1'b1; shift_fn = 1'b1; end
            6'h08:               begin funct_ok = 1'b1; jr_fn    = 1'b1; end
            6'h09:               begin funct_ok = 1'b1; jalr_fn  = 1'b1; end
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2a, 6'h2b:        funct_ok = 1'b1;
            default:             ;
        endcase
    end

    // Opcode classification
    assign r_type     = (op == 6'h00);
    assign is_r_alu   = r_type & funct_ok & ~jr_fn & ~jalr_fn;
    assign is_jr      = r_type & jr_fn;
    assign is_jalr    = r_type & jalr_fn;
    assign is_j       = (op == 6'h02);
    assign is_jal     = (op == 6'h03);
    assign is_br      = (op == 6'h04) | (EXT_BRANCH & (op == 6'h05));
    assign is_lw      = (op == 6'h23);
    assign is_sw      = (op == 6'h2b);
    assign is_lui     = (op == 6'h0f);
    assign is_imm_alu = (op >= 6'h08) & (op <= 6'h0c);
    assign is_itype   = is_imm_alu | is_lui | is_lw | is_sw;
    assign legal      = r_type ? funct_ok : (is_itype | is_br | is_j | is_jal);

    // Low ALUOp bits used in EX/MEM/WB; keyed purely on the opcode
    always_comb begin
        alu_lo = 3'b000;
        if (r_type)                             alu_lo = 3'b010;
        else if (op == 6'h04 || op == 6'h05)    alu_lo = 3'b001;
        else if (op == 6'h0c)                   alu_lo = 3'b011;
        else if (op == 6'h0a || op == 6'h0b)    alu_lo = 3'b100;
    end

    // Next-state and datapath decode
    always_comb begin
        state_d       = S_IF;
        ctl_c         = '0;
        ctl_c.alu_op  = {op[0], 3'b000};
        case (state_q)
            S_IF: begin
                ctl_c.mem_read  = 1'b1;
                ctl_c.alu_src_b = 2'b01;
                ctl_c.ir_write  = mem_go;
                ctl_c.pc_write  = mem_go;
                state_d         = mem_go ? S_ID : S_IF;
            end
            S_ID: begin
                ctl_c.alu_src_b = 2'b11;
                ctl_c.ext_op    = 1'b1;
                state_d         = (!legal && ILLEGAL_TRAP) ? S_TRAP : S_EX;
            end
            S_EX: begin
                ctl_c.alu_op[2:0] = alu_lo;
                if (is_r_alu) begin
                    ctl_c.alu_src_a = shift_fn ? 2'b10 : 2'b01;
                    state_d         = S_WB;
                end else if (is_jr || is_jalr) begin
                    ctl_c.pc_source = 2'b11;
                    ctl_c.pc_write  = 1'b1;
                    if (is_jalr) begin
                        ctl_c.reg_dst    = 2'b01;
                        ctl_c.mem_to_reg = 2'b10;
                        ctl_c.reg_write  = 1'b1;
                    end
                end else if (is_itype) begin
                    ctl_c.alu_src_a = 2'b01;
                    ctl_c.alu_src_b = 2'b10;
                    ctl_c.ext_op    = (op != 6'h0c);
                    ctl_c.lui_op    = is_lui;
                    state_d         = (is_lw || is_sw) ? S_MEM : S_WB;
                end else if (is_br) begin
                    ctl_c.pc_write_cond = 1'b1;
                    ctl_c.alu_src_a     = 2'b01;
                    ctl_c.pc_source     = 2'b01;
                    ctl_c.branch_ne     = (op == 6'h05);
                end else if (is_j || is_jal) begin
                    ctl_c.pc_write  = 1'b1;
                    ctl_c.pc_source = 2'b10;
                    if (is_jal) begin
                        ctl_c.reg_dst    = 2'b10;
                        ctl_c.mem_to_reg = 2'b10;
                        ctl_c.reg_write  = 1'b1;
                    end
                end
                // undecoded instructions fall back to IF as no-ops
            end
            S_MEM: begin
                ctl_c.alu_op[2:0] = alu_lo;
                ctl_c.i_or_d      = 1'b1;
                ctl_c.mem_read    = is_lw;
                ctl_c.mem_write   = is_sw;
                if (!mem_go)    state_d = S_MEM;
                else if (is_lw) state_d = S_WB;
            end
            S_WB: begin
                ctl_c.alu_op[2:0] = alu_lo;
                ctl_c.reg_write   = 1'b1;
                if (is_lw) begin
                    ctl_c.mem_to_reg = 2'b00;
                end else if (is_lui) begin
                    ctl_c.mem_to_reg = 2'b11;
                end else if (is_itype) begin
                    ctl_c.mem_to_reg = 2'b01;
                end else if (r_type) begin
                    ctl_c.reg_dst    = 2'b01;
                    ctl_c.mem_to_reg = 2'b01;
                end
            end
            S_TRAP: begin
                ctl_c.exception = 1'b1;
            end
            default: state_d = S_IF;
        endcase
    end

    // Only completions out of EX/MEM/WB count; TRAP and IF stalls do not
    assign retire_c  = (state_d == S_IF) &&
                       (state_q == S_EX || state_q == S_MEM || state_q == S_WB);
    assign retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IF;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Reset blanks every decode output immediately, without waiting for a clock
    assign ctl_out_c = reset ? ctl_c : '0;

    assign bus.PCWrite     = ctl_out_c.pc_write;
    assign bus.PCWriteCond = ctl_out_c.pc_write_cond;
    assign bus.IorD        = ctl_out_c.i_or_d;
    assign bus.MemWrite    = ctl_out_c.mem_write;
    assign bus.MemRead     = ctl_out_c.mem_read;
    assign bus.IRWrite     = ctl_out_c.ir_write;
    assign bus.RegWrite    = ctl_out_c.reg_write;
    assign bus.ExtOp       = ctl_out_c.ext_op;
    assign bus.LuiOp       = ctl_out_c.lui_op;
    assign bus.MemtoReg    = ctl_out_c.mem_to_reg;
    assign bus.RegDst      = ctl_out_c.reg_dst;
    assign bus.ALUSrcA     = ctl_out_c.alu_src_a;
    assign bus.ALUSrcB     = ctl_out_c.alu_src_b;
    assign bus.PCSource    = ctl_out_c.pc_source;
    assign bus.ALUOp       = ctl_out_c.alu_op;
    assign bus.BranchNe    = ctl_out_c.branch_ne;
    assign bus.Exception   = ctl_out_c.exception;
    assign bus.state_o     = state_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_gen2.sv
// Bench for multicycle_ctrl_gen2: three parameterisations driven side by side,
// each compared every cycle against an instruction-class reference model, plus
// directed literal checks for the add/lw/bne/j-wrap/reset-mid-sw scenarios.
module tb_multicycle_ctrl_gen2;

    typedef struct packed {
        logic       pcw, pcwc, iord, memw, memr, irw, regw, extop, luiop;
        logic [1:0] m2r, rdst, asa, asb, pcs;
        logic [3:0] aluop;
        logic       brne, exc;
    } ctl_t;

    localparam int C_RALU = 0, C_SHIFT = 1, C_JR = 2, C_JALR = 3, C_IMM = 4,
                   C_LUI = 5, C_LW = 6, C_SW = 7, C_BR = 8, C_J = 9,
                   C_JAL = 10, C_BAD = 11;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bit hs_p  [3] = '{1'b1, 1'b1, 1'b0};
    bit ext_p [3] = '{1'b1, 1'b0, 1'b1};
    bit trp_p [3] = '{1'b1, 1'b1, 1'b0};
    int w_p   [3] = '{32, 2, 8};

    logic [5:0] op_s [3];
    logic [5:0] fn_s [3];
    logic       rdy_s[3];

    multicycle_ctrl_gen2_if #(.CNT_W(32)) if0();
    multicycle_ctrl_gen2_if #(.CNT_W(2))  if1();
    multicycle_ctrl_gen2_if #(.CNT_W(8))  if2();

    multicycle_ctrl_gen2 #(.MEM_HANDSHAKE(1'b1), .EXT_BRANCH(1'b1), .ILLEGAL_TRAP(1'b1), .CNT_W(32))
        dut0 (.clk(clk), .reset(reset), .bus(if0.master));
    multicycle_ctrl_gen2 #(.MEM_HANDSHAKE(1'b1), .EXT_BRANCH(1'b0), .ILLEGAL_TRAP(1'b1), .CNT_W(2))
        dut1 (.clk(clk), .reset(reset), .bus(if1.master));
    multicycle_ctrl_gen2 #(.MEM_HANDSHAKE(1'b0), .EXT_BRANCH(1'b1), .ILLEGAL_TRAP(1'b0), .CNT_W(8))
        dut2 (.clk(clk), .reset(reset), .bus(if2.master));

    assign if0.OpCode = op_s[0]; assign if0.Funct = fn_s[0]; assign if0.mem_ready = rdy_s[0];
    assign if1.OpCode = op_s[1]; assign if1.Funct = fn_s[1]; assign if1.mem_ready = rdy_s[1];
    assign if2.OpCode = op_s[2]; assign if2.Funct = fn_s[2]; assign if2.mem_ready = rdy_s[2];

    function automatic ctl_t pk(input logic pcw, pcwc, iord, memw, memr, irw, regw, extop, luiop,
                                input logic [1:0] m2r, rdst, asa, asb, pcs,
                                input logic [3:0] aluop, input logic brne, exc);
        pk = '{pcw, pcwc, iord, memw, memr, irw, regw, extop, luiop,
               m2r, rdst, asa, asb, pcs, aluop, brne, exc};
    endfunction

    ctl_t        act    [3];
    logic [2:0]  act_st [3];
    logic [31:0] act_ret[3];

    assign act[0] = pk(if0.PCWrite, if0.PCWriteCond, if0.IorD, if0.MemWrite, if0.MemRead, if0.IRWrite,
                       if0.RegWrite, if0.ExtOp, if0.LuiOp, if0.MemtoReg, if0.RegDst, if0.ALUSrcA,
                       if0.ALUSrcB, if0.PCSource, if0.ALUOp, if0.BranchNe, if0.Exception);
    assign act[1] = pk(if1.PCWrite, if1.PCWriteCond, if1.IorD, if1.MemWrite, if1.MemRead, if1.IRWrite,
                       if1.RegWrite, if1.ExtOp, if1.LuiOp, if1.MemtoReg, if1.RegDst, if1.ALUSrcA,
                       if1.ALUSrcB, if1.PCSource, if1.ALUOp, if1.BranchNe, if1.Exception);
    assign act[2] = pk(if2.PCWrite, if2.PCWriteCond, if2.IorD, if2.MemWrite, if2.MemRead, if2.IRWrite,
                       if2.RegWrite, if2.ExtOp, if2.LuiOp, if2.MemtoReg, if2.RegDst, if2.ALUSrcA,
                       if2.ALUSrcB, if2.PCSource, if2.ALUOp, if2.BranchNe, if2.Exception);
    assign act_st[0]  = if0.state_o;
    assign act_st[1]  = if1.state_o;
    assign act_st[2]  = if2.state_o;
    assign act_ret[0] = if0.retired;
    assign act_ret[1] = 32'(if1.retired);
    assign act_ret[2] = 32'(if2.retired);

    int nchk  = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        nchk++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, a, e);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int cls(input logic [5:0] op, input logic [5:0] fn, input bit ext);
        if (op == 6'h00) begin
            case (fn)
                6'h00, 6'h02, 6'h03: return C_SHIFT;
                6'h08:               return C_JR;
                6'h09:               return C_JALR;
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2a, 6'h2b:        return C_RALU;
                default:             return C_BAD;
            endcase
        end
        case (op)
            6'h02:                             return C_J;
            6'h03:                             return C_JAL;
            6'h04:                             return C_BR;
            6'h05:                             return ext ? C_BR : C_BAD;
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c: return C_IMM;
            6'h0f:                             return C_LUI;
            6'h23:                             return C_LW;
            6'h2b:                             return C_SW;
            default:                           return C_BAD;
        endcase
    endfunction

    function automatic logic [2:0] alu_class(input logic [5:0] op);
        if (op == 6'h00) return 3'b010;
        if (op == 6'h04 || op == 6'h05) return 3'b001;
        if (op == 6'h0c) return 3'b011;
        if (op == 6'h0a || op == 6'h0b) return 3'b100;
        return 3'b000;
    endfunction

    function automatic ctl_t exp_out(input int st, input logic [5:0] op, input logic [5:0] fn,
                                     input logic rdy, input bit hs, input bit ext);
        ctl_t c = '0;
        bit   go = hs ? rdy : 1'b1;
        int   k  = cls(op, fn, ext);
        c.aluop[3] = op[0];
        if (st >= 2 && st <= 4) c.aluop[2:0] = alu_class(op);
        case (st)
            0: begin c.memr = 1; c.asb = 2'b01; c.irw = go; c.pcw = go; end
            1: begin c.asb = 2'b11; c.extop = 1; end
            2: case (k)
                C_RALU:  c.asa = 2'b01;
                C_SHIFT: c.asa = 2'b10;
                C_JR:    begin c.pcs = 2'b11; c.pcw = 1; end
                C_JALR:  begin c.pcs = 2'b11; c.pcw = 1; c.rdst = 2'b01; c.m2r = 2'b10; c.regw = 1; end
                C_IMM, C_LUI, C_LW, C_SW: begin
                    c.asa = 2'b01; c.asb = 2'b10;
                    c.extop = (op != 6'h0c); c.luiop = (op == 6'h0f);
                end
                C_BR:    begin c.pcwc = 1; c.asa = 2'b01; c.pcs = 2'b01; c.brne = (op == 6'h05); end
                C_J:     begin c.pcw = 1; c.pcs = 2'b10; end
                C_JAL:   begin c.pcw = 1; c.pcs = 2'b10; c.rdst = 2'b10; c.m2r = 2'b10; c.regw = 1; end
                default: ;
            endcase
            3: begin c.iord = 1; c.memr = (k == C_LW); c.memw = (k == C_SW); end
            4: begin
                c.regw = 1;
                if (k == C_LUI) c.m2r = 2'b11;
                else if (k == C_IMM || k == C_SW) c.m2r = 2'b01;
                else if (k != C_LW) begin c.rdst = 2'b01; c.m2r = 2'b01; end
            end
            5: c.exc = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic int exp_next(input int st, input logic [5:0] op, input logic [5:0] fn,
                                    input logic rdy, input bit hs, input bit ext, input bit trp);
        bit go = hs ? rdy : 1'b1;
        int k  = cls(op, fn, ext);
        case (st)
            0: return go ? 1 : 0;
            1: return (k == C_BAD && trp) ? 5 : 2;
            2: case (k)
                C_RALU, C_SHIFT, C_IMM, C_LUI: return 4;
                C_LW, C_SW:                    return 3;
                default:                       return 0;
            endcase
            3: return go ? ((k == C_LW) ? 4 : 0) : 3;
            default: return 0;
        endcase
    endfunction

    int              ms[3];
    longint unsigned mr[3];

    // Per-cycle comparison of all three DUTs against the model
    initial begin : cmp_proc
        ctl_t            e;
        int              nx[3];
        longint unsigned nr[3];
        longint unsigned mask;
        for (int k = 0; k < 3; k++) begin ms[k] = 0; mr[k] = 0; end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                mask = (64'd1 << w_p[k]) - 64'd1;
                if (!reset) begin
                    e = '0; nx[k] = 0; nr[k] = 0;
                    chk($sformatf("dut%0d ctl(reset)", k), 64'(act[k]), 64'(e));
                    chk($sformatf("dut%0d state(reset)", k), 64'(act_st[k]), 64'd0);
                    chk($sformatf("dut%0d retired(reset)", k), 64'(act_ret[k]), 64'd0);
                end else begin
                    e     = exp_out(ms[k], op_s[k], fn_s[k], rdy_s[k], hs_p[k], ext_p[k]);
                    nx[k] = exp_next(ms[k], op_s[k], fn_s[k], rdy_s[k], hs_p[k], ext_p[k], trp_p[k]);
                    nr[k] = (nx[k] == 0 && ms[k] >= 2 && ms[k] <= 4) ? mr[k] + 1 : mr[k];
                    chk($sformatf("dut%0d ctl st%0d op%0h fn%0h", k, ms[k], op_s[k], fn_s[k]),
                        64'(act[k]), 64'(e));
                    chk($sformatf("dut%0d state", k), 64'(act_st[k]), 64'(ms[k]));
                    chk($sformatf("dut%0d retired", k), 64'(act_ret[k]), mr[k] & mask);
                end
            end
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!reset) begin ms[k] = 0; mr[k] = 0; end
                else begin ms[k] = nx[k]; mr[k] = nr[k]; end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [5:0] o, input logic [5:0] f, input logic r);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin op_s[k] = o; fn_s[k] = f; rdy_s[k] = r; end
        @(negedge clk);
    endtask

    task automatic pick(output logic [5:0] o, output logic [5:0] f);
        logic [5:0] ops_l[12];
        logic [5:0] fns_l[16];
        int r;
        ops_l = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h23, 6'h2b};
        fns_l = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                  6'h26, 6'h27, 6'h2a, 6'h2b, 6'h2b};
        r = $urandom_range(0, 9);
        if (r < 3) begin
            o = 6'h00; f = fns_l[$urandom_range(0, 15)];
        end else if (r < 9) begin
            o = ops_l[$urandom_range(0, 11)]; f = 6'($urandom);
        end else begin
            o = 6'($urandom); f = 6'($urandom);
        end
    endtask

    initial begin : main_proc
        logic [1:0] wrap_exp[5];
        logic [5:0] o, f;
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin op_s[k] = 6'h00; fn_s[k] = 6'h20; rdy_s[k] = 1'b1; end
        repeat (2) @(negedge clk);
        chk("reset MemRead gated", 64'(if0.MemRead), 64'd0);
        chk("reset IRWrite gated", 64'(if0.IRWrite), 64'd0);
        chk("reset state", 64'(if0.state_o), 64'd0);

        // five jumps: counter wrap on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            step(6'h02, 6'h00, 1'b1);
            chk("j IF state", 64'(if0.state_o), 64'd0);
            chk("j retired dut0", 64'(if0.retired), 64'(i));
            if (i > 0) chk("wrap retired dut1", 64'(if1.retired), 64'(wrap_exp[i-1]));
            step(6'h02, 6'h00, 1'b1);
            chk("j ID state", 64'(if0.state_o), 64'd1);
            step(6'h02, 6'h00, 1'b1);
            chk("j EX state", 64'(if0.state_o), 64'd2);
            chk("j EX PCWrite", 64'(if0.PCWrite), 64'd1);
            chk("j EX PCSource", 64'(if0.PCSource), 64'd2);
        end

        // add
        step(6'h00, 6'h20, 1'b1);
        chk("wrap retired dut1", 64'(if1.retired), 64'(wrap_exp[4]));
        chk("add IF retired", 64'(if0.retired), 64'd5);
        step(6'h00, 6'h20, 1'b1);
        chk("add ID ALUSrcB", 64'(if0.ALUSrcB), 64'd3);
        step(6'h00, 6'h20, 1'b1);
        chk("add EX state", 64'(if0.state_o), 64'd2);
        chk("add EX ALUOp", 64'(if0.ALUOp), 64'b0010);
        step(6'h00, 6'h20, 1'b1);
        chk("add WB state", 64'(if0.state_o), 64'd4);
        chk("add WB RegWrite", 64'(if0.RegWrite), 64'd1);
        chk("add WB RegDst", 64'(if0.RegDst), 64'd1);
        chk("add WB MemtoReg", 64'(if0.MemtoReg), 64'd1);

        // bne: branch on dut0, trap on dut1
        step(6'h05, 6'h00, 1'b1);
        chk("add retired", 64'(if0.retired), 64'd6);
        step(6'h05, 6'h00, 1'b1);
        step(6'h05, 6'h00, 1'b1);
        chk("bne PCWriteCond", 64'(if0.PCWriteCond), 64'd1);
        chk("bne BranchNe", 64'(if0.BranchNe), 64'd1);
        chk("bne PCSource", 64'(if0.PCSource), 64'd1);
        chk("bne ALUOp", 64'(if0.ALUOp), 64'b1001);
        chk("trap state dut1", 64'(if1.state_o), 64'd5);
        chk("trap Exception dut1", 64'(if1.Exception), 64'd1);

        // lw with two wait cycles in MEM
        step(6'h23, 6'h00, 1'b1);
        chk("trap over dut1", 64'(if1.Exception), 64'd0);
        chk("trap no retire dut1", 64'(if1.retired), 64'd2);
        chk("bne retired dut0", 64'(if0.retired), 64'd7);
        step(6'h23, 6'h00, 1'b1);
        step(6'h23, 6'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(6'h23, 6'h00, (i == 2));
            chk("lw MEM state", 64'(if0.state_o), 64'd3);
            chk("lw MEM MemRead", 64'(if0.MemRead), 64'd1);
            chk("lw MEM IorD", 64'(if0.IorD), 64'd1);
        end
        step(6'h23, 6'h00, 1'b1);
        chk("lw WB state", 64'(if0.state_o), 64'd4);
        chk("lw WB MemtoReg", 64'(if0.MemtoReg), 64'd0);

        // sw interrupted by reset in MEM
        step(6'h2b, 6'h00, 1'b1);
        chk("lw retired", 64'(if0.retired), 64'd8);
        step(6'h2b, 6'h00, 1'b1);
        step(6'h2b, 6'h00, 1'b1);
        step(6'h2b, 6'h00, 1'b0);
        chk("sw MEM MemWrite", 64'(if0.MemWrite), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("sw reset MemWrite", 64'(if0.MemWrite), 64'd0);
        chk("sw reset state", 64'(if0.state_o), 64'd0);
        chk("sw reset retired", 64'(if0.retired), 64'd0);
        step(6'h00, 6'h20, 1'b1);
        chk("post-reset state", 64'(if0.state_o), 64'd0);
        chk("post-reset retired", 64'(if0.retired), 64'd0);
        chk("post-reset MemRead", 64'(if0.MemRead), 64'd1);

        // random instruction streams; new instruction only while in IF
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (ms[k] == 0) begin
                    pick(o, f);
                    op_s[k] = o;
                    fn_s[k] = f;
                end
                rdy_s[k] = ($urandom_range(0, 9) < 7);
            end
            if ($urandom_range(0, 299) == 0) #3 reset = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
